// File: rtl/usb_rx_packet_decoder.sv
// USB RX packet decoder: checks PIDs and CRCs on the unstuffed byte stream, filters
// tokens by address/endpoint, reports a packet code and forwards DATA payload bytes.
module usb_rx_packet_decoder #(
   parameter logic [6:0] DEV_ADDR    = 7'd0,
   parameter logic [3:0] ENDPOINT    = 4'd0,
   parameter int         MAX_PAYLOAD = 64
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_byte_valid,
   input  logic [7:0] i_rx_byte,
   input  logic       i_eop,
   input  logic       i_line_err,
   output logic [2:0] o_rx_packet,
   output logic       o_store_rx_packet_data,
   output logic [7:0] o_rx_packet_data,
   output logic       o_rx_busy
);

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;

   localparam logic [2:0] PKT_IDLE = 3'b000;
   localparam logic [2:0] PKT_DATA = 3'b001;
   localparam logic [2:0] PKT_OUT  = 3'b010;
   localparam logic [2:0] PKT_IN   = 3'b011;
   localparam logic [2:0] PKT_ACK  = 3'b100;
   localparam logic [2:0] PKT_NAK  = 3'b101;
   localparam logic [2:0] PKT_BAD  = 3'b110;

   localparam logic [4:0]  CRC5_INIT   = 5'h1F;
   localparam logic [4:0]  CRC5_POLY   = 5'h05;
   localparam logic [4:0]  CRC5_RESID  = 5'b01100;
   localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY  = 16'h8005;
   localparam logic [15:0] CRC16_RESID = 16'h800D;

   // Byte counter covers the payload plus the two trailing CRC bytes.
   localparam int               CNT_W     = $clog2(MAX_PAYLOAD + 3);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PAYLOAD + 2);
   localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TOK1,
      S_TOK2,
      S_TOK_EOP,
      S_HS_EOP,
      S_DATA,
      S_ERR_DRAIN,
      S_REPORT
   } state_t;

   function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
      logic [4:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[4] ^ data[i]) begin
            c = {c[3:0], 1'b0} ^ CRC5_POLY;
         end else begin
            c = {c[3:0], 1'b0};
         end
      end
      return c;
   endfunction

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[15] ^ data[i]) begin
            c = {c[14:0], 1'b0} ^ CRC16_POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   state_t           r_state;
   logic [2:0]       r_rx_packet;
   logic             r_store;
   logic [7:0]       r_data;
   logic             r_busy;
   logic [2:0]       r_code;
   logic [4:0]       r_crc5;
   logic [15:0]      r_crc16;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_tok0;
   logic             r_match;
   logic [7:0]       r_skid0;
   logic [7:0]       r_skid1;

   state_t           w_pid_state;
   logic [2:0]       w_pid_pkt;
   logic [2:0]       w_pid_code;

   // Classify the incoming byte as a PID: next state, immediate code, latched code.
   always_comb begin
      w_pid_state = S_ERR_DRAIN;
      w_pid_pkt   = PKT_BAD;
      w_pid_code  = PKT_BAD;
      if (i_rx_byte[7:4] == ~i_rx_byte[3:0]) begin
         case (i_rx_byte)
            PID_OUT: begin
               w_pid_state = S_TOK1;
               w_pid_pkt   = PKT_IDLE;
               w_pid_code  = PKT_OUT;
            end
            PID_IN: begin
               w_pid_state = S_TOK1;
               w_pid_pkt   = PKT_IDLE;
               w_pid_code  = PKT_IN;
            end
            PID_DATA0, PID_DATA1: begin
               w_pid_state = S_DATA;
               w_pid_pkt   = PKT_DATA;
               w_pid_code  = PKT_DATA;
            end
            PID_ACK: begin
               w_pid_state = S_HS_EOP;
               w_pid_pkt   = PKT_IDLE;
               w_pid_code  = PKT_ACK;
            end
            PID_NAK: begin
               w_pid_state = S_HS_EOP;
               w_pid_pkt   = PKT_IDLE;
               w_pid_code  = PKT_NAK;
            end
            default: begin
               w_pid_state = S_ERR_DRAIN;
               w_pid_pkt   = PKT_BAD;
               w_pid_code  = PKT_BAD;
            end
         endcase
      end else begin
         w_pid_state = S_ERR_DRAIN;
         w_pid_pkt   = PKT_BAD;
         w_pid_code  = PKT_BAD;
      end
   end

   // Packet FSM with registered outputs, CRC accumulators and payload skid buffer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rx_packet <= PKT_IDLE;
         r_store     <= 1'b0;
         r_data      <= 8'h00;
         r_busy      <= 1'b0;
         r_code      <= PKT_IDLE;
         r_crc5      <= CRC5_INIT;
         r_crc16     <= CRC16_INIT;
         r_cnt       <= '0;
         r_tok0      <= 8'h00;
         r_match     <= 1'b0;
         r_skid0     <= 8'h00;
         r_skid1     <= 8'h00;
      end else begin
         r_store <= 1'b0;
         if (i_line_err && (r_state != S_IDLE) && (r_state != S_REPORT)) begin
            r_rx_packet <= PKT_BAD;
            r_code      <= PKT_BAD;
            r_state     <= i_eop ? S_REPORT : S_ERR_DRAIN;
         end else begin
            case (r_state)
               // A PID arriving during REPORT starts the next packet straight away.
               S_IDLE, S_REPORT: begin
                  r_rx_packet <= (r_state == S_REPORT) ? r_code : PKT_IDLE;
                  if (i_byte_valid) begin
                     r_state <= w_pid_state;
                     r_code  <= w_pid_code;
                     r_busy  <= 1'b1;
                     r_crc5  <= CRC5_INIT;
                     r_crc16 <= CRC16_INIT;
                     r_cnt   <= '0;
                     if (r_state == S_IDLE) begin
                        r_rx_packet <= w_pid_pkt;
                     end
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               S_TOK1: begin
                  r_rx_packet <= PKT_IDLE;
                  if (i_byte_valid) begin
                     r_crc5  <= crc5_byte(r_crc5, i_rx_byte);
                     r_tok0  <= i_rx_byte;
                     r_state <= S_TOK2;
                  end else if (i_eop) begin
                     r_code  <= PKT_BAD;
                     r_state <= S_REPORT;
                  end
               end
               S_TOK2: begin
                  r_rx_packet <= PKT_IDLE;
                  if (i_byte_valid) begin
                     r_crc5  <= crc5_byte(r_crc5, i_rx_byte);
                     r_match <= (r_tok0[6:0] == DEV_ADDR) &&
                                ({i_rx_byte[2:0], r_tok0[7]} == ENDPOINT);
                     r_state <= S_TOK_EOP;
                  end else if (i_eop) begin
                     r_code  <= PKT_BAD;
                     r_state <= S_REPORT;
                  end
               end
               S_TOK_EOP: begin
                  r_rx_packet <= PKT_IDLE;
                  if (i_eop) begin
                     if (r_crc5 != CRC5_RESID) begin
                        r_code  <= PKT_BAD;
                        r_state <= S_REPORT;
                     end else if (r_match) begin
                        r_state <= S_REPORT;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else if (i_byte_valid) begin
                     r_rx_packet <= PKT_BAD;
                     r_state     <= S_ERR_DRAIN;
                  end
               end
               S_HS_EOP: begin
                  r_rx_packet <= PKT_IDLE;
                  if (i_eop) begin
                     r_state <= S_REPORT;
                  end else if (i_byte_valid) begin
                     r_rx_packet <= PKT_BAD;
                     r_state     <= S_ERR_DRAIN;
                  end
               end
               // The two newest bytes stay in the skid pair, so the CRC bytes never leave it.
               S_DATA: begin
                  r_rx_packet <= PKT_DATA;
                  if (i_eop) begin
                     r_state <= S_REPORT;
                     r_code  <= ((r_cnt < CNT_TWO) || (r_crc16 != CRC16_RESID)) ? PKT_BAD : PKT_IDLE;
                  end else if (i_byte_valid) begin
                     if (r_cnt >= CNT_LIMIT) begin
                        r_rx_packet <= PKT_BAD;
                        r_state     <= S_ERR_DRAIN;
                     end else begin
                        r_crc16 <= crc16_byte(r_crc16, i_rx_byte);
                        r_skid0 <= r_skid1;
                        r_skid1 <= i_rx_byte;
                        r_cnt   <= r_cnt + CNT_ONE;
                        if (r_cnt >= CNT_TWO) begin
                           r_store <= 1'b1;
                           r_data  <= r_skid0;
                        end
                     end
                  end
               end
               S_ERR_DRAIN: begin
                  r_rx_packet <= PKT_BAD;
                  if (i_eop) begin
                     r_code  <= PKT_BAD;
                     r_state <= S_REPORT;
                  end
               end
               default: begin
                  r_rx_packet <= PKT_IDLE;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_rx_packet            = r_rx_packet;
   assign o_store_rx_packet_data = r_store;
   assign o_rx_packet_data       = r_data;
   assign o_rx_busy              = r_busy;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Scoreboard bench for usb_rx_packet_decoder: stimulus queues timed expected events,
// a negedge monitor pops and compares them against packet-code changes and store strobes.
module tb_usb_rx_packet_decoder;

   localparam int         MAXP     = 64;
   localparam logic [2:0] PK_IDLE  = 3'b000;
   localparam logic [2:0] PK_DATA  = 3'b001;
   localparam logic [2:0] PK_OUT   = 3'b010;
   localparam logic [2:0] PK_IN    = 3'b011;
   localparam logic [2:0] PK_ACK   = 3'b100;
   localparam logic [2:0] PK_NAK   = 3'b101;
   localparam logic [2:0] PK_BAD   = 3'b110;

   typedef struct {
      bit         is_store;
      logic [7:0] val;
      int         at;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       eop;
   logic       line_err;
   logic [2:0] rx_packet;
   logic       store;
   logic [7:0] pdata;
   logic       busy;
   logic [2:0] w5_pkt;
   logic       w5_store;
   logic [7:0] w5_data;
   logic       w5_busy;

   exp_t       exp_q[$];
   logic [7:0] pay[0:MAXP+3];
   int         cyc = 0;
   int         rst_chk_at = -1;
   int         final_at = -1;
   bit         mon_en = 1'b0;
   bit         chk5 = 1'b0;
   logic [2:0] prev_pkt = 3'b000;
   int         n_checks = 0;
   int         n_pass = 0;

   usb_rx_packet_decoder u_dut (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .i_rx_byte(rx_byte),
      .i_eop(eop), .i_line_err(line_err), .o_rx_packet(rx_packet),
      .o_store_rx_packet_data(store), .o_rx_packet_data(pdata), .o_rx_busy(busy)
   );

   usb_rx_packet_decoder #(.DEV_ADDR(7'd5)) u_dut5 (
      .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .i_rx_byte(rx_byte),
      .i_eop(eop), .i_line_err(line_err), .o_rx_packet(w5_pkt),
      .o_store_rx_packet_data(w5_store), .o_rx_packet_data(w5_data), .o_rx_busy(w5_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void exp_pkt(input logic [2:0] code, input int at);
      exp_q.push_back('{1'b0, {5'b00000, code}, at});
   endfunction

   function automatic void exp_store(input logic [7:0] d, input int at);
      exp_q.push_back('{1'b1, d, at});
   endfunction

   // Reference CRC16 over pay[0..n-1], bit-serial LSB first.
   function automatic logic [15:0] crc16_of(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[15] ^ pay[i][j];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
         end
      end
      return c;
   endfunction

   always @(negedge clk) begin : mon
      int   c;
      int   p;
      exp_t e;
      c = 0;
      p = 0;
      if (cyc == rst_chk_at) begin
         c++;
         if ({rx_packet, store, pdata, busy, w5_pkt, w5_store, w5_data, w5_busy} === 26'd0) p++;
         else $display("FAIL reset_outputs: got pkt=%b store=%b data=%h busy=%b (dut5 %b %b %h %b), required all zero",
                       rx_packet, store, pdata, busy, w5_pkt, w5_store, w5_data, w5_busy);
      end
      if (chk5) begin
         c++;
         if ({w5_pkt, w5_store, w5_data} === 12'd0) p++;
         else $display("FAIL addr_filter: dut5 got pkt=%b store=%b data=%h at cycle %0d, required 000/0/00",
                       w5_pkt, w5_store, w5_data, cyc);
      end
      if (mon_en && store !== 1'b0) begin
         c++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_store: got data=%h at cycle %0d, required no event", pdata, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.is_store && store === 1'b1 && e.val === pdata && e.at == cyc) p++;
            else $display("FAIL store_event: got store data=%h at cycle %0d, required %s %h at cycle %0d",
                          pdata, cyc, e.is_store ? "store" : "packet", e.val, e.at);
         end
      end
      if (mon_en && rx_packet !== prev_pkt) begin
         c++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_packet: got rx_packet=%b at cycle %0d, required no event", rx_packet, cyc);
         end else begin
            e = exp_q.pop_front();
            if (!e.is_store && e.val === {5'b00000, rx_packet} && e.at == cyc) p++;
            else $display("FAIL packet_event: got rx_packet=%b at cycle %0d, required %s %h at cycle %0d",
                          rx_packet, cyc, e.is_store ? "store" : "packet", e.val, e.at);
         end
      end
      if (cyc == final_at) begin
         c++;
         if (exp_q.size() == 0) p++;
         else $display("FAIL missing_events: got %0d expected events never seen, required 0", exp_q.size());
      end
      prev_pkt <= rx_packet;
      n_checks <= n_checks + c;
      n_pass   <= n_pass + p;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      rx_byte    = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_eop();
      eop = 1'b1;
      tick();
      eop = 1'b0;
   endtask

   task automatic token_pkt(input logic [7:0] pid, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [2:0] code);
      int t;
      send_byte(pid);
      send_byte(b1);
      send_byte(b2);
      t = cyc;
      if (code != PK_IDLE) begin
         exp_pkt(code, t + 2);
         exp_pkt(PK_IDLE, t + 3);
      end
      send_eop();
      idle(5);
   endtask

   task automatic hs_pkt(input logic [7:0] pid, input logic [2:0] code);
      int t;
      t = cyc;
      if (code == PK_BAD) exp_pkt(PK_BAD, t + 1);
      send_byte(pid);
      idle(2);
      t = cyc;
      if (code != PK_BAD) exp_pkt(code, t + 2);
      exp_pkt(PK_IDLE, t + 3);
      send_eop();
      idle(5);
   endtask

   task automatic data_pkt(input logic [7:0] pid, input int n, input logic [7:0] crc_xor);
      logic [15:0] c;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b;
      int          t;
      c = ~crc16_of(n);
      for (int k = 0; k < 8; k++) begin
         b0[k] = c[15 - k];
         b1[k] = c[7 - k];
      end
      b1 = b1 ^ crc_xor;
      t = cyc;
      exp_pkt(PK_DATA, t + 1);
      send_byte(pid);
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) b = pay[i];
         else if (i == n) b = b0;
         else b = b1;
         t = cyc;
         if (i >= 2 && i < MAXP + 2) exp_store(pay[i - 2], t + 1);
         else if (i == MAXP + 2) exp_pkt(PK_BAD, t + 1);
         send_byte(b);
      end
      t = cyc;
      if (n > MAXP) begin
         exp_pkt(PK_IDLE, t + 3);
      end else if (crc_xor != 8'h00) begin
         exp_pkt(PK_BAD, t + 2);
         exp_pkt(PK_IDLE, t + 3);
      end else begin
         exp_pkt(PK_IDLE, t + 2);
      end
      send_eop();
      idle(5);
   endtask

   initial begin
      int t;
      for (int i = 0; i <= MAXP + 3; i++) pay[i] = 8'(i + 1);
      rst        = 1'b1;
      byte_valid = 1'b0;
      rx_byte    = 8'h00;
      eop        = 1'b0;
      line_err   = 1'b0;
      rst_chk_at = cyc + 1;
      idle(2);
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(2);

      chk5 = 1'b1;
      token_pkt(8'hE1, 8'h00, 8'h10, PK_OUT);
      chk5 = 1'b0;
      token_pkt(8'hE1, 8'h00, 8'h11, PK_BAD);
      token_pkt(8'h69, 8'h00, 8'h10, PK_IN);

      data_pkt(8'hC3, 4, 8'h00);
      data_pkt(8'hC3, 4, 8'h01);
      data_pkt(8'h4B, 0, 8'h00);

      hs_pkt(8'hD2, PK_ACK);
      hs_pkt(8'h5A, PK_NAK);
      hs_pkt(8'hD3, PK_BAD);

      // ACK immediately followed by NAK whose PID lands in the report cycle.
      t = cyc;
      send_byte(8'hD2);
      send_eop();
      exp_pkt(PK_ACK, t + 3);
      exp_pkt(PK_IDLE, t + 4);
      exp_pkt(PK_NAK, t + 5);
      exp_pkt(PK_IDLE, t + 6);
      send_byte(8'h5A);
      send_eop();
      idle(5);

      // line_err in the middle of a DATA packet.
      t = cyc;
      exp_pkt(PK_DATA, t + 1);
      send_byte(8'hC3);
      send_byte(8'h01);
      send_byte(8'h02);
      t = cyc;
      exp_store(8'h01, t + 1);
      send_byte(8'h03);
      t = cyc;
      exp_pkt(PK_BAD, t + 1);
      line_err = 1'b1;
      tick();
      line_err = 1'b0;
      send_byte(8'h04);
      send_byte(8'h05);
      t = cyc;
      exp_pkt(PK_IDLE, t + 3);
      send_eop();
      idle(5);

      data_pkt(8'hC3, MAXP + 3, 8'h00);

      // Reset in the middle of a DATA packet, then a clean ACK.
      t = cyc;
      exp_pkt(PK_DATA, t + 1);
      send_byte(8'hC3);
      send_byte(8'h01);
      send_byte(8'h02);
      t = cyc;
      exp_store(8'h01, t + 1);
      send_byte(8'h03);
      t = cyc;
      exp_pkt(PK_IDLE, t + 1);
      rst_chk_at = t + 1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(2);
      hs_pkt(8'hD2, PK_ACK);

      idle(3);
      final_at = cyc + 1;
      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
